npu_dot_mac: RTL
================

// Module: npu_dot_mac
// PURPOSE
//   Parametrised N-lane signed dot-product MAC for the NPU datapath. It generalises the 2-lane
//   multiply-add primitive to N_LANES products per beat, summed by an adder tree. Sums are
//   accumulated across multi-beat vectors framed by first/last, with valid/ready handshakes on
//   both sides. Optional saturation and an overflow flag are provided. Sits between the
//   operand fetch stream and the activation/requant stage.
// PARAMETERS
//   N_LANES   4   products per beat (>=1)
//   A_W       18  signed width of each A operand
//   B_W       18  signed width of each B operand
//   ACC_W     48  accumulator/output width; must be >= A_W+B_W+$clog2(N_LANES) (elaboration error otherwise)
//   SATURATE  0   1: accumulator clamps at signed limits; 0: two's-complement wrap
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   ce         in   1               global clock enable; 0 freezes every register
//   in_valid   in   1               beat valid
//   in_ready   out  1               beat accepted when in_valid & in_ready at a rising edge
//   in_first   in   1               beat starts a vector (accumulator reloads)
//   in_last    in   1               beat ends a vector (result emitted)
//   in_a       in   N_LANES*A_W     packed signed A, lane i = in_a[i*A_W +: A_W]
//   in_b       in   N_LANES*B_W     packed signed B, same packing
//   out_valid  out  1               result valid
//   out_ready  in   1               downstream accepts result
//   out_data   out  ACC_W           signed dot-product result
//   out_ovf    out  1               signed overflow occurred during this vector
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valid bits, out_valid, out_data, out_ovf, accumulator = 0;
//     vector state = closed. Reset mid-vector discards the partial vector; no output is produced for it.
//   - Advance enable: en = ce & (~out_valid | out_ready); in_ready = en (combinational).
//     en=0 holds every stage incl. out_data/out_ovf stable; no beat lost or duplicated.
//   - Pipeline (all advance on en): S1 input register; S2 N_LANES products (A_W+B_W each);
//     S3 adder tree sum, sign-extended to ACC_W; S4 accumulate + output register.
//     Bubbles carry valid=0 and do not touch the accumulator.
//   - Latency: last beat accepted at edge k -> out_valid=1 after edge k+3 when no stall;
//     each stalled cycle adds one. Throughput one beat/cycle.
//   - Accumulate at S4: first=1 or vector closed -> acc = sum, vector ovf cleared;
//     else acc = acc + sum. A non-first beat while closed is treated as first.
//   - Overflow: signed overflow of acc+sum sets vector ovf; SATURATE=1 clamps acc to
//     2^(ACC_W-1)-1 / -2^(ACC_W-1), and later beats continue from the clamped value;
//     SATURATE=0 wraps.
//   - last=1 at S4: out_data = new acc, out_ovf = vector ovf, out_valid=1, vector closes.
//     first&last together is a single-beat dot product.
//   - out_valid clears on out_valid & out_ready unless a new result loads that same edge
//     (back-to-back results allowed).
//   - Non-last beats never raise out_valid.
// TESTING
//   1 N_LANES=4: one beat first=last=1, a=[1,2,3,4], b=[5,6,7,8] -> out_data=70, ovf=0, 3 cycles after accept
//   2 all lanes a=b=-131072 (A_W=B_W=18), single beat -> out_data=68719476736 (2^36), ovf=0
//   3 3-beat vector, all a=100, b=-3 -> exactly one out_valid, out_data=-3600;
//     then single-beat vector of zeros -> out_data=0 (reload verified)
//   4 back-to-back single-beat vectors with out_ready=0 for 5 cycles -> in_ready drops;
//     out_data stable while held; all results in order, none lost
//   5 ACC_W=40, SATURATE=1: 20 beats each summing 2^36 -> out_data=2^39-1, ovf=1;
//     SATURATE=0 -> wrapped value, ovf=1
//   6 rst_n low mid 3-beat vector -> outputs 0 immediately; next vector result correct, no stale output;
//     plus 1000 random vectors (lengths 1-8, random ce/out_ready) checked against a reference model

Source files
------------

// File: rtl/npu_dot_mac.sv
// N-lane signed dot-product MAC: register, multiply, sum and accumulate stages.
// Vectors are framed by first/last, and a single elastic enable stalls the whole pipe.
module npu_dot_mac #(
  parameter int N_LANES  = 4,
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int ACC_W    = 48,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [N_LANES*A_W-1:0]   in_a,
  input  logic [N_LANES*B_W-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_ovf
);

  localparam int P_W = A_W + B_W;
  localparam int MIN_ACC_W = P_W + $clog2(N_LANES);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  generate
    if (ACC_W < MIN_ACC_W) begin : g_acc_w_check
      $error("npu_dot_mac: ACC_W too narrow for A_W+B_W+clog2(N_LANES)");
    end
  endgenerate

  logic                      en;
  logic                      v1_r, f1_r, l1_r;
  logic [N_LANES*A_W-1:0]    a1_r;
  logic [N_LANES*B_W-1:0]    b1_r;
  logic                      v2_r, f2_r, l2_r;
  logic signed [P_W-1:0]     p2_r [N_LANES];
  logic                      v3_r, f3_r, l3_r;
  logic signed [ACC_W-1:0]   s3_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic                      open_r, vovf_r;

  logic signed [P_W-1:0]     prod_s [N_LANES];
  logic signed [ACC_W-1:0]   tree_s;
  logic                      reload_s, ovf_s, vovf_nx_s;
  logic [ACC_W:0]            wide_s;
  logic signed [ACC_W-1:0]   acc_nx_s;

  // A stalled output blocks every stage, so nothing upstream can be overwritten.
  assign en       = ce & (~out_valid | out_ready);
  assign in_ready = en;

  // Per-lane signed products from the input register
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      prod_s[i] = P_W'($signed(a1_r[i*A_W +: A_W])) * P_W'($signed(b1_r[i*B_W +: B_W]));
    end
  end

  // Sum of lane products, sign-extended to the accumulator width
  always_comb begin
    tree_s = '0;
    for (int i = 0; i < N_LANES; i++) begin
      tree_s = tree_s + ACC_W'(p2_r[i]);
    end
  end

  // Next accumulator value, overflow detection and optional clamping
  always_comb begin
    reload_s  = f3_r | ~open_r;
    wide_s    = {acc_r[ACC_W-1], acc_r} + {s3_r[ACC_W-1], s3_r};
    ovf_s     = 1'b0;
    vovf_nx_s = 1'b0;
    acc_nx_s  = s3_r;
    if (reload_s) begin
      acc_nx_s  = s3_r;
      vovf_nx_s = 1'b0;
    end else begin
      ovf_s     = wide_s[ACC_W] ^ wide_s[ACC_W-1];
      vovf_nx_s = vovf_r | ovf_s;
      if (ovf_s && (SATURATE != 32'sd0)) begin
        acc_nx_s = wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_nx_s = wide_s[ACC_W-1:0];
      end
    end
  end

  // Input, product and sum stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0; f1_r <= 1'b0; l1_r <= 1'b0;
      a1_r <= '0;   b1_r <= '0;
      v2_r <= 1'b0; f2_r <= 1'b0; l2_r <= 1'b0;
      for (int i = 0; i < N_LANES; i++) p2_r[i] <= '0;
      v3_r <= 1'b0; f3_r <= 1'b0; l3_r <= 1'b0;
      s3_r <= '0;
    end else if (en) begin
      v1_r <= in_valid; f1_r <= in_first; l1_r <= in_last;
      a1_r <= in_a;     b1_r <= in_b;
      v2_r <= v1_r;     f2_r <= f1_r;     l2_r <= l1_r;
      for (int i = 0; i < N_LANES; i++) p2_r[i] <= prod_s[i];
      v3_r <= v2_r;     f3_r <= f2_r;     l3_r <= l2_r;
      s3_r <= tree_s;
    end
  end

  // Accumulator, vector framing and output register; bubbles leave state untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      open_r    <= 1'b0;
      vovf_r    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= v3_r & l3_r;
      if (v3_r) begin
        acc_r  <= acc_nx_s;
        vovf_r <= vovf_nx_s;
        open_r <= ~l3_r;
        if (l3_r) begin
          out_data <= acc_nx_s;
          out_ovf  <= vovf_nx_s;
        end
      end
    end
  end

endmodule
